sum_loader: RTL and testbench

SUM_LOADER -- requirements
Module: sum_loader

---
 rtl/sum_loader.sv | 94 +++++++++
 tb/tb_sum_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sum_loader.sv
// sum_loader: collects two 32-bit operands from a byte stream (A then B,
// each LSB first), presents them to an external adder for one cycle, and
// holds the registered sum until the consumer acknowledges it.
module sum_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        c_in,
  input  logic        clr,
  input  logic        res_ack,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        c_out_req,
  input  logic [31:0] s,
  input  logic        c_outfinal,
  output logic [31:0] result,
  output logic        result_cout,
  output logic        result_valid,
  output logic        busy
);

  typedef enum logic [1:0] {LOAD, ADD, DONE} state_t;

  state_t      state_q;
  logic [2:0]  byte_cnt_q;
  logic [31:0] a_q, b_q, res_q;
  logic        cin_q, rcout_q, rvld_q;

  // Byte index inside the current operand, scaled to a bit offset.
  logic [4:0]  bit_ofs;
  assign bit_ofs = {byte_cnt_q[1:0], 3'b000};

  // Sequencer: load eight bytes, one adder cycle, hold result until ack.
  // rst beats clr, and clr beats everything else; clr keeps the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      byte_cnt_q <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      cin_q      <= 1'b0;
      res_q      <= 32'd0;
      rcout_q    <= 1'b0;
      rvld_q     <= 1'b0;
    end else if (clr) begin
      state_q    <= LOAD;
      byte_cnt_q <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      cin_q      <= 1'b0;
      rvld_q     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (din_valid) begin
            if (!byte_cnt_q[2]) a_q[bit_ofs +: 8] <= din;
            else                b_q[bit_ofs +: 8] <= din;
            if (byte_cnt_q == 3'd0) cin_q <= c_in;
            // Counter wraps to 0 naturally after byte 7.
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) state_q <= ADD;
          end
        end
        ADD: begin
          res_q   <= s;
          rcout_q <= c_outfinal;
          rvld_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (res_ack) begin
            state_q <= LOAD;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cin_q   <= 1'b0;
            rvld_q  <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Outputs are straight from registers; busy decodes the state only.
  assign a            = a_q;
  assign b            = b_q;
  assign c_out_req    = cin_q;
  assign result       = res_q;
  assign result_cout  = rcout_q;
  assign result_valid = rvld_q;
  assign busy         = (state_q != LOAD);

endmodule

// File: tb/tb_sum_loader.sv
// Bench for sum_loader: directed operand loads with hand-computed sums,
// a result scoreboard popped by an independent monitor, plus direct
// checks of operand registers, timing, clr and rst behaviour.
module tb_sum_loader;
  logic        clk = 1'b0;
  logic        rst, din_valid, c_in, clr, res_ack;
  logic [7:0]  din;
  logic [31:0] a, b, s, result;
  logic        c_out_req, c_outfinal, result_cout, result_valid, busy;
  logic [32:0] sum33;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  // Downstream adder the block drives.
  assign sum33      = {1'b0, a} + {1'b0, b} + {32'd0, c_out_req};
  assign s          = sum33[31:0];
  assign c_outfinal = sum33[32];

  sum_loader dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .c_in(c_in),
    .clr(clr), .res_ack(res_ack), .a(a), .b(b), .c_out_req(c_out_req),
    .s(s), .c_outfinal(c_outfinal), .result(result),
    .result_cout(result_cout), .result_valid(result_valid), .busy(busy)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ci);
    din = v; din_valid = 1'b1; c_in = ci;
    cyc();
    din_valid = 1'b0; c_in = 1'b0;
  endtask

  // Send A then B (LSB first) and queue the hand-computed {cout,sum}.
  task automatic load(input logic [31:0] va, input logic [31:0] vb, input logic ci,
                      input logic [31:0] er, input logic ec);
    exp_q.push_back({ec, er});
    for (int i = 0; i < 4; i++) send_byte(va[i*8 +: 8], (i == 0) ? ci : 1'b0);
    for (int i = 0; i < 4; i++) send_byte(vb[i*8 +: 8], 1'b0);
  endtask

  // Called right after the last byte: one ADD cycle, then DONE with valid.
  task automatic check_done(input string tag);
    chk({tag, "_add_busy"}, {32'd0, busy}, 33'd1);
    chk({tag, "_add_vld"},  {32'd0, result_valid}, 33'd0);
    cyc();
    chk({tag, "_done_vld"}, {32'd0, result_valid}, 33'd1);
  endtask

  task automatic ack();
    res_ack = 1'b1;
    cyc();
    res_ack = 1'b0;
    chk("ack_busy", {32'd0, busy}, 33'd0);
    chk("ack_vld",  {32'd0, result_valid}, 33'd0);
    chk("ack_a",    {1'b0, a}, 33'd0);
    chk("ack_cin",  {32'd0, c_out_req}, 33'd0);
  endtask

  // Monitor: each new result presentation consumes one scoreboard entry.
  initial begin
    logic prev_vld;
    logic [32:0] e;
    prev_vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (result_valid && !prev_vld) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got %h want none", {result_cout, result});
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", {result_cout, result}, e);
        end
      end
      prev_vld = result_valid;
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; res_ack = 1'b0; din_valid = 1'b0; din = 8'h00; c_in = 1'b0;
    cyc(); cyc();
    chk("rst_a", {1'b0, a}, 33'd0);
    chk("rst_b", {1'b0, b}, 33'd0);
    chk("rst_res", {result_cout, result}, 33'd0);
    chk("rst_flags", {30'd0, c_out_req, result_valid, busy}, 33'd0);
    rst = 1'b0;
    cyc();

    // Signed-looking overflow: 0x7FFFFFFF + 0x80000001 = 2^32.
    load(32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1);
    chk("v1_a", {1'b0, a}, {1'b0, 32'h7FFF_FFFF});
    chk("v1_b", {1'b0, b}, {1'b0, 32'h8000_0001});
    check_done("v1");
    ack();

    // Decimal vector, ack withheld: valid and busy must persist.
    load(32'd1021201, 32'd1457454, 1'b0, 32'h0025_D23F, 1'b0);
    check_done("v2");
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("v2_hold", {31'd0, result_valid, busy}, 33'd3);
    end
    chk("v2_res", {result_cout, result}, {1'b0, 32'd2478655});
    ack();

    // Carry-in on byte 0 rolls all-ones over.
    load(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    chk("v3_cin", {32'd0, c_out_req}, 33'd1);
    check_done("v3");
    ack();

    // Partial load aborted by clr (coinciding with a byte), result retained.
    for (int i = 0; i < 5; i++) send_byte(8'hA5, 1'b1);
    clr = 1'b1; din = 8'h5A; din_valid = 1'b1;
    cyc();
    clr = 1'b0; din_valid = 1'b0;
    chk("clr_ab", {1'b0, a | b}, 33'd0);
    chk("clr_flags", {31'd0, c_out_req, busy}, 33'd0);
    chk("clr_keep", {result_cout, result}, {1'b1, 32'h0});
    load(32'd65535656, 32'd11112441, 1'b0, 32'd76648097, 1'b0);
    chk("v4_a", {1'b0, a}, {1'b0, 32'd65535656});
    check_done("v4");

    // clr together with res_ack behaves as clr: result kept, valid dropped.
    clr = 1'b1; res_ack = 1'b1;
    cyc();
    clr = 1'b0; res_ack = 1'b0;
    chk("clrack_vld", {31'd0, result_valid, busy}, 33'd0);
    chk("clrack_keep", {result_cout, result}, {1'b0, 32'd76648097});

    // Stray bytes during ADD and DONE (including with res_ack) are dropped.
    load(32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0);
    din = 8'hAA; din_valid = 1'b1;
    cyc();                      // ADD
    chk("v5_vld", {32'd0, result_valid}, 33'd1);
    cyc();                      // DONE
    res_ack = 1'b1;
    cyc();
    res_ack = 1'b0; din_valid = 1'b0;
    chk("v5_a", {1'b0, a}, 33'd0);
    chk("v5_busy", {32'd0, busy}, 33'd0);
    load(32'd1, 32'd1, 1'b0, 32'd2, 1'b0);
    chk("v6_a", {1'b0, a}, 33'd1);
    check_done("v6");
    ack();

    // rst during DONE wipes everything; a later load still works.
    load(32'd5, 32'd6, 1'b0, 32'd11, 1'b0);
    check_done("v7");
    rst = 1'b1; clr = 1'b1; res_ack = 1'b1;
    cyc();
    rst = 1'b0; clr = 1'b0; res_ack = 1'b0;
    chk("rst2_res", {result_cout, result}, 33'd0);
    chk("rst2_ab", {1'b0, a | b}, 33'd0);
    chk("rst2_flags", {30'd0, c_out_req, result_valid, busy}, 33'd0);
    load(32'd100, 32'd200, 1'b0, 32'd300, 1'b0);
    check_done("v8");
    ack();

    cyc();
    chk("sb_empty", exp_q.size(), 33'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
